// File: rtl/ramb4_s2_rd_master.sv
// Burst read master for one port of a 2048 x 2-bit RAMB4_S2 block RAM.
// Issues up to one read per cycle and forwards the returned words as a
// valid/ready stream through a two-entry buffer, marking the final beat.
module ramb4_s2_rd_master #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [10:0] BASE_ADDR,
    input  logic [11:0] LEN,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic [10:0] ADDR,
    output logic        EN,
    output logic        WE,
    output logic        SSR,
    output logic [1:0]  DI,
    input  logic [1:0]  DO,
    output logic [1:0]  M_DATA,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic        M_LAST
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t      state;
    logic [10:0] base_q;       // burst start address
    logic [11:0] eff_len;      // burst length after clamping / end-of-RAM cut
    logic [11:0] issued_cnt;   // reads issued so far
    logic [11:0] beat_cnt;     // beats handed to the stream so far
    logic        inflight;     // a read was sampled last edge; DO is valid now
    logic [1:0]  fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;          // buffer occupancy, 0..2

    logic [11:0] req_len;
    logic [11:0] room;
    logic [11:0] start_len;
    logic        pop;
    logic        last_issue;
    logic        last_beat;

    // Length a new burst will run for: clamp to the RAM size, and when not
    // wrapping, stop at the top address.
    // NOTE: every variable here is assigned on every path, so no latch is inferred.
    always_comb begin
        req_len   = (LEN > 12'd2048) ? 12'd2048 : LEN;
        room      = 12'd2048 - {1'b0, BASE_ADDR};
        start_len = req_len;
        if (!WRAP_EN && (room < req_len)) begin
            start_len = room;
        end
    end

    // The write side of the RAM port is permanently idle.
    assign WE  = 1'b0;
    assign SSR = 1'b0;
    assign DI  = 2'b00;

    // Stream side comes straight from the buffer head so data holds while stalled.
    assign M_VALID   = (occ != 2'd0);
    assign M_DATA    = fifo_mem[rd_ptr];
    assign M_LAST    = M_VALID && ((beat_cnt + 12'd1) == eff_len);
    assign pop       = M_VALID && M_READY;
    assign last_beat = pop && M_LAST;

    // A read is issued only if its word is guaranteed a buffer slot when it
    // returns, counting the slot freed by this cycle's pop.
    assign EN = (state == ISSUE)
             && (({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
    assign last_issue = EN && ((issued_cnt + 12'd1) == eff_len);
    assign ADDR       = base_q + issued_cnt[10:0];
    assign BUSY       = (state != IDLE);

    // Burst FSM, issue/beat counters and the return-data buffer.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            base_q      <= '0;
            eff_len     <= '0;
            issued_cnt  <= '0;
            beat_cnt    <= '0;
            inflight    <= 1'b0;
            occ         <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            DONE        <= 1'b0;
            // NOTE: the two buffer words are reset so M_DATA reads 0 after reset;
            // a deep memory would be left unreset and gated instead.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (ABORT) begin
            // Cancel: drop buffered words and ignore the read still in flight.
            state      <= IDLE;
            issued_cnt <= '0;
            beat_cnt   <= '0;
            inflight   <= 1'b0;
            occ        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE     <= 1'b0;
            inflight <= EN;
            if (inflight) begin
                fifo_mem[wr_ptr] <= DO;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + 12'd1;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
            if (EN) begin
                issued_cnt <= issued_cnt + 12'd1;
            end

            case (state)
                IDLE: begin
                    if (START) begin
                        base_q     <= BASE_ADDR;
                        eff_len    <= start_len;
                        issued_cnt <= '0;
                        beat_cnt   <= '0;
                        if (start_len == 12'd0) begin
                            DONE <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ramb4_s2_rd_master.md
RAMB4_S2_RD_MASTER -- requirements
Module: ramb4_s2_rd_master

Interface
REQ-001 Parameter: WRAP_EN, default 1, meaning: 1 = address wraps 2047->0 during a burst; 0 = a burst reaching 2047 ends after that word.
REQ-002 CLK  input  1  single clock; all logic on its rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 START  input  1  burst request; sampled only in IDLE.
REQ-005 BASE_ADDR  input  11  first word address; latched on accepted START.
REQ-006 LEN  input  12  word count; latched on accepted START; 0 = empty burst; >2048 clamped to 2048.
REQ-007 ABORT  input  1  synchronous burst cancel.
REQ-008 BUSY  output  1  high from the accepted START until the burst ends.
REQ-009 DONE  output  1  one-cycle pulse on burst completion.
REQ-010 ADDR  output  11  RAM port address.
REQ-011 EN  output  1  RAM port enable; one read per cycle in which it is high.
REQ-012 WE  output  1  RAM port write enable; constant 0.
REQ-013 SSR  output  1  RAM port output reset; constant 0.
REQ-014 DI  output  2  RAM port write data; constant 2'b00.
REQ-015 DO  input  2  RAM port read data; valid the cycle after the edge that sampled EN=1.
REQ-016 M_DATA  output  2  stream data.
REQ-017 M_VALID  output  1  stream valid.
REQ-018 M_READY  input  1  stream ready; a beat transfers when M_VALID & M_READY.
REQ-019 M_LAST  output  1  high with the final beat of the burst.

Function
REQ-020 States: IDLE, ISSUE, DRAIN.
- IDLE->ISSUE on START with LEN!=0.
- ISSUE->DRAIN when the last read has been issued.
- DRAIN->IDLE on the M_LAST handshake.
REQ-021 START with LEN=0 in IDLE: no EN, DONE pulses the following cycle, BUSY stays 0; START while BUSY is ignored.
REQ-022 Read issue:
- ADDR = BASE_ADDR + issued_count (mod 2048).
- EN asserted only in ISSUE, and only when (buffer occupancy + reads in flight - pop this cycle) < 2.
REQ-023 Return-data buffer: 2 entries, FIFO order, loaded with DO one cycle after each issued read; never overflows and never loses a word.
REQ-024 M_DATA/M_VALID are driven from the buffer head; M_VALID=1 whenever the buffer is non-empty; M_DATA is stable while M_VALID & !M_READY.
REQ-025 Latency and throughput:
- START sampled at edge E0 -> EN=1 with ADDR=BASE_ADDR sampled at E1 -> M_VALID=1 after E2.
- With M_READY held 1, the block sustains 1 beat per cycle.
REQ-026 M_LAST=1 exactly on beat number LEN (post-clamp).
REQ-027 DONE pulses the cycle after the M_LAST handshake; BUSY falls on the same edge that raises DONE.
REQ-028 WRAP_EN=0 and the burst reaches address 2047:
- effective length = 2048 - BASE_ADDR when that is less than LEN;
- M_LAST is on the word read from address 2047.
REQ-029 ABORT in any state, applied at edge En:
- outputs after En: ISSUE/DRAIN -> IDLE, buffer flushed, M_VALID=0, EN=0, BUSY=0;
- no DONE pulse;
- any in-flight DO is discarded.
REQ-030 ABORT and START in the same cycle: ABORT wins, START is dropped.
REQ-031 EN is never asserted while M_READY=0 and the buffer plus in-flight reads total 2.

Reset
REQ-032 RST=1 sampled at an edge forces IDLE, clears the buffer and counters, and holds these output values: BUSY=0, DONE=0, EN=0, ADDR=0, M_VALID=0, M_LAST=0, M_DATA=2'b00.
REQ-033 RST mid-burst takes effect at the next edge with the same values as REQ-032; no DONE pulse.
REQ-034 RST has priority over START and ABORT.
REQ-035 The first START is accepted on the first edge after RST deasserts.

Verification
REQ-036 Full-throughput burst: RAM preloaded with word[i]=i[1:0]; START, BASE_ADDR=5, LEN=8, M_READY=1.
- Response: EN high 8 consecutive cycles, ADDR 5..12.
- Beats 1,2,3,0,1,2,3,0; M_LAST on beat 8; DONE 1 cycle later.
REQ-037 Backpressure: LEN=6 with M_READY toggling 1,0,0,1,...
- Response: beats arrive in order with no loss or duplication.
- EN never asserted with 2 words outstanding.
- M_DATA held stable while stalled.
REQ-038 Wrap handling: BASE_ADDR=2046, LEN=4.
- WRAP_EN=1: ADDR sequence 2046, 2047, 0, 1.
- WRAP_EN=0: 2 beats, M_LAST on the word from address 2047.
REQ-039 Empty and clamped lengths:
- LEN=0: no EN, DONE pulse next cycle.
- LEN=4095: exactly 2048 beats, M_LAST on beat 2048.
REQ-040 ABORT and reset:
- ABORT on beat 3 of LEN=10: M_VALID=0 next cycle, no DONE; a new START is accepted the following cycle.
- RST mid-burst: all outputs per REQ-032.
REQ-041 START while BUSY is ignored; simultaneous ABORT+START in IDLE starts nothing.
